// File: rtl/cpu_clock_control_pkg.sv
// Shared types and encodings for the CPU run-control block.
// State values are visible on the state port and decoded by monitors.
package cpu_clock_control_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    CC_HOLD   = 2'd0,
    CC_IDLE   = 2'd1,
    CC_RUN    = 2'd2,
    CC_HALTED = 2'd3
  } cc_state_e;

endpackage

// File: rtl/reset_synchronizer.sv
// Two-flop reset synchronizer: asynchronous assert, synchronous deassert.
module reset_synchronizer (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 1'b0;
      sync_rst_n <= 1'b0;
    end else begin
      meta_q     <= 1'b1;
      sync_rst_n <= meta_q;
    end
  end

endmodule

// File: rtl/cpu_clock_control.sv
// Run-control for the core: stretched core reset plus a registered clock
// enable implementing run, pause, single-step, halt and a cycle-budget timeout.
module cpu_clock_control
  import cpu_clock_control_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter int unsigned CYCLE_WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   run_req,
  input  logic                   step_req,
  input  logic                   halt_req,
  input  logic                   halt_detect,
  output logic                   cpu_reset_n,
  output logic                   cpu_enable,
  output logic [STATE_W-1:0]     state,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic                   timeout
);

  localparam logic [HOLD_CNT_W-1:0]  HOLD_LAST   = HOLD_CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_VAL = CYCLE_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                     TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  cc_state_e                 state_q;
  cc_state_e                 state_d;
  logic [HOLD_CNT_W-1:0]     hold_cnt_q;
  logic                      step_prev_q;
  logic                      sync_rst_n;
  logic                      step_edge;
  logic                      halt_cmd;
  logic                      timeout_hit;
  logic                      enable_d;
  logic                      timeout_d;
  logic [CYCLE_WIDTH-1:0]    cycle_inc;

  reset_synchronizer u_rst_sync (
    .clk        (clock),
    .rst_n      (reset_n),
    .sync_rst_n (sync_rst_n)
  );

  assign step_edge   = step_req & ~step_prev_q;
  assign halt_cmd    = halt_req | (halt_detect & cpu_enable);
  assign cycle_inc   = (cycle_count == '1) ? cycle_count : cycle_count + CYCLE_WIDTH'(1);
  // Budget fires on the enabled cycle that brings the count up to the limit.
  assign timeout_hit = TIMEOUT_EN && cpu_enable && (cycle_inc == TIMEOUT_VAL);

  // State register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CC_HOLD;
      cpu_reset_n <= 1'b0;
      cpu_enable  <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      hold_cnt_q  <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_reset_n <= (state_d != CC_HOLD);
      cpu_enable  <= enable_d;
      timeout     <= timeout_d;
      step_prev_q <= step_req;
      if (cpu_enable) begin
        cycle_count <= cycle_inc;
      end
      if (state_q == CC_HOLD && sync_rst_n) begin
        hold_cnt_q <= hold_cnt_q + HOLD_CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CC_HOLD: begin
        if (sync_rst_n && hold_cnt_q == HOLD_LAST) begin
          state_d = CC_IDLE;
        end
      end
      CC_IDLE, CC_RUN: begin
        if (halt_cmd || timeout_hit) begin
          state_d = CC_HALTED;
        end else if (state_q == CC_IDLE && step_edge) begin
          state_d = CC_IDLE;
        end else if (run_req) begin
          state_d = CC_RUN;
        end else begin
          state_d = CC_IDLE;
        end
      end
      CC_HALTED: state_d = CC_HALTED;
      default:   state_d = CC_HOLD;
    endcase
  end

  // Next values for the registered enable and sticky timeout flag
  always_comb begin
    enable_d  = 1'b0;
    timeout_d = timeout;
    case (state_q)
      CC_IDLE: begin
        enable_d  = ~halt_cmd & ~timeout_hit & (step_edge | run_req);
        timeout_d = timeout | (~halt_cmd & timeout_hit);
      end
      CC_RUN: begin
        enable_d  = ~halt_cmd & ~timeout_hit & run_req;
        timeout_d = timeout | (~halt_cmd & timeout_hit);
      end
      default: begin
        enable_d  = 1'b0;
        timeout_d = timeout;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_clock_control.sv
// Self-checking bench for cpu_clock_control: table vectors, corner sequences
// and randomized traffic against a behavioural model (budgets 0 and 20).
module tb_cpu_clock_control;

  localparam int HOLD = 4;

  logic        clock;
  logic        reset_n;
  logic        run_req;
  logic        step_req;
  logic        halt_req;
  logic        halt_detect;

  logic        rstn0, en0, tmo0;
  logic [1:0]  st0;
  logic [31:0] cnt0;
  logic        rstn1, en1, tmo1;
  logic [1:0]  st1;
  logic [31:0] cnt1;

  int checks = 0;
  int errors = 0;

  cpu_clock_control #(.RESET_HOLD_CYCLES(HOLD), .CYCLE_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .halt_detect(halt_detect), .cpu_reset_n(rstn0),
    .cpu_enable(en0), .state(st0), .cycle_count(cnt0), .timeout(tmo0)
  );

  cpu_clock_control #(.RESET_HOLD_CYCLES(HOLD), .CYCLE_WIDTH(32), .TIMEOUT_CYCLES(20)) dut20 (
    .clock(clock), .reset_n(reset_n), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .halt_detect(halt_detect), .cpu_reset_n(rstn1),
    .cpu_enable(en1), .state(st1), .cycle_count(cnt1), .timeout(tmo1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model, one slot per instance
  int     m_tlim [2];
  int     m_rel  [2];
  int     m_st   [2];
  bit     m_en   [2];
  bit     m_tmo  [2];
  bit     m_prev [2];
  bit     m_rstn [2];
  longint m_cnt  [2];

  typedef struct {
    bit     run;
    bit     step;
    bit     hreq;
    bit     hdet;
    bit     e_rstn;
    int     e_st;
    bit     e_en;
    longint e_cnt;
    bit     e_tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit run, input bit step, input bit hreq, input bit hdet,
                              input bit e_rstn, input int e_st, input bit e_en,
                              input longint e_cnt, input bit e_tmo);
    vec_t v;
    v.run = run; v.step = step; v.hreq = hreq; v.hdet = hdet;
    v.e_rstn = e_rstn; v.e_st = e_st; v.e_en = e_en; v.e_cnt = e_cnt; v.e_tmo = e_tmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rel[i] = 0; m_st[i] = 0; m_en[i] = 0; m_tmo[i] = 0;
      m_prev[i] = 0; m_rstn[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // One rising edge with reset_n high, applying the request priority rules.
  task automatic model_edge(input bit run, input bit step, input bit hreq, input bit hdet);
    for (int i = 0; i < 2; i++) begin
      bit sedge;
      bit en_now;
      sedge     = step && !m_prev[i];
      m_prev[i] = step;
      en_now    = m_en[i];
      m_rel[i]++;
      if (m_st[i] == 0) begin
        if (m_rel[i] == 2 + HOLD) begin
          m_st[i]   = 1;
          m_rstn[i] = 1;
        end
      end else if (m_st[i] != 3) begin
        if (hreq || (hdet && en_now)) begin
          m_st[i] = 3; m_en[i] = 0;
        end else if (m_tlim[i] != 0 && en_now && m_cnt[i] + 1 == m_tlim[i]) begin
          m_st[i] = 3; m_en[i] = 0; m_tmo[i] = 1;
        end else if (m_st[i] == 1 && sedge) begin
          m_en[i] = 1;
        end else if (run) begin
          m_st[i] = 2; m_en[i] = 1;
        end else begin
          m_st[i] = 1; m_en[i] = 0;
        end
      end
      if (en_now && m_cnt[i] < 64'h0000_0000_FFFF_FFFF) m_cnt[i]++;
    end
  endtask

  task automatic compare_all();
    chk("t0_rstn",  rstn0, m_rstn[0]);
    chk("t0_en",    en0,   m_en[0]);
    chk("t0_state", st0,   m_st[0]);
    chk("t0_count", cnt0,  m_cnt[0]);
    chk("t0_tmo",   tmo0,  m_tmo[0]);
    chk("t20_rstn",  rstn1, m_rstn[1]);
    chk("t20_en",    en1,   m_en[1]);
    chk("t20_state", st1,   m_st[1]);
    chk("t20_count", cnt1,  m_cnt[1]);
    chk("t20_tmo",   tmo1,  m_tmo[1]);
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, checks.
  task automatic tick(input bit rst, input bit run, input bit step, input bit hreq, input bit hdet);
    reset_n = rst; run_req = run; step_req = step; halt_req = hreq; halt_detect = hdet;
    if (!rst) model_reset();
    else      model_edge(run, step, hreq, hdet);
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic reset_assert();
    reset_n = 1'b0; run_req = 0; step_req = 0; halt_req = 0; halt_detect = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
  endtask

  task automatic restart();
    reset_assert();
    repeat (HOLD + 2) tick(1, 0, 0, 0, 0);
  endtask

  initial begin
    m_tlim[0] = 0;
    m_tlim[1] = 20;
    model_reset();
    reset_n = 0; run_req = 0; step_req = 0; halt_req = 0; halt_detect = 0;

    // Release, run 10, step sequence, halt_req racing run_req
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    for (int k = 1; k <= 10; k++) vecs.push_back(mk(1, 0, 0, 0, 1, 2, 1, k - 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 10, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 10, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 10, 0));
    for (int k = 2; k <= 5; k++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 11, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 11, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 11, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 12, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 3, 0, 12, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 3, 0, 12, 0));

    @(negedge clock);
    reset_assert();
    foreach (vecs[i]) begin
      tick(1, vecs[i].run, vecs[i].step, vecs[i].hreq, vecs[i].hdet);
      chk($sformatf("vec%0d_rstn", i),  rstn0, vecs[i].e_rstn);
      chk($sformatf("vec%0d_state", i), st0,   vecs[i].e_st);
      chk($sformatf("vec%0d_en", i),    en0,   vecs[i].e_en);
      chk($sformatf("vec%0d_count", i), cnt0,  vecs[i].e_cnt);
      chk($sformatf("vec%0d_tmo", i),   tmo0,  vecs[i].e_tmo);
    end

    // halt_detect on the 7th enabled cycle; later run_req ignored
    restart();
    repeat (7) tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 1);
    chk("hdet_state", st0, 3);
    chk("hdet_count", cnt0, 7);
    chk("hdet_tmo", tmo0, 0);
    chk("hdet_en", en0, 0);
    repeat (3) tick(1, 1, 0, 0, 0);
    chk("hdet_after_state", st0, 3);
    chk("hdet_after_count", cnt0, 7);

    // Budget of 20 exhausted while running
    restart();
    for (int k = 1; k <= 25; k++) begin
      tick(1, 1, 0, 0, 0);
      if (k == 20) chk("tmo_last_en", en1, 1);
      if (k == 21) chk("tmo_hit_en", en1, 0);
    end
    chk("tmo_state", st1, 3);
    chk("tmo_count", cnt1, 20);
    chk("tmo_flag", tmo1, 1);
    chk("notmo_state", st0, 2);
    chk("notmo_count", cnt0, 24);
    chk("notmo_flag", tmo0, 0);

    // Asynchronous reset mid-run at count 13
    restart();
    repeat (14) tick(1, 1, 0, 0, 0);
    chk("midrun_count_before", cnt0, 13);
    reset_n = 1'b0;
    #1;
    chk("midrun_rstn", rstn0, 0);
    chk("midrun_en", en0, 0);
    chk("midrun_state", st0, 0);
    chk("midrun_count", cnt0, 0);
    model_reset();
    compare_all();
    @(negedge clock);
    for (int k = 1; k <= HOLD + 2; k++) begin
      tick(1, 1, 0, 0, 0);
      chk($sformatf("rehold%0d_rstn", k), rstn0, (k == HOLD + 2) ? 1 : 0);
    end
    chk("rehold_en", en0, 0);
    chk("rehold_count", cnt0, 0);

    // halt_req together with a step edge: no enabled cycle
    restart();
    tick(1, 0, 1, 1, 0);
    chk("stephalt_state", st0, 3);
    chk("stephalt_en", en0, 0);
    chk("stephalt_count", cnt0, 0);

    // halt_detect on the last permitted step cycle counts as halt
    restart();
    repeat (19) tick(1, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    chk("laststep_en", en1, 1);
    tick(1, 0, 1, 0, 1);
    chk("laststep_state", st1, 3);
    chk("laststep_count", cnt1, 20);
    chk("laststep_tmo", tmo1, 0);

    // Randomized traffic against the model
    for (int seg = 0; seg < 4; seg++) begin
      restart();
      for (int n = 0; n < 400; n++) begin
        bit r_rst, r_run, r_step, r_hreq, r_hdet;
        r_rst  = ($urandom_range(0, 199) != 0);
        r_run  = ($urandom_range(0, 99) < 70);
        r_step = ($urandom_range(0, 2) == 0);
        r_hreq = ($urandom_range(0, 299) == 0);
        r_hdet = ($urandom_range(0, 99) < 2);
        tick(r_rst, r_run, r_step, r_hreq, r_hdet);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
